noise_prng_128e: RTL and testbench

- Masking-noise source for the protected AES-128e round stages (encryption and key expansion).
- Generates registered pseudo-random words sized for NSTAGES consumers, each taking 7 byte-lanes of masking noise (6 for the inverter, 1 for the S-box).
- Built from a bank of 32-bit Galois LFSR lanes, with seeding, warm-up, consumer-paced advance and sticky fault detection.
- Sits directly upstream of the stage noise inputs.

---
 rtl/noise_prng_128e.sv | 106 ++++++++++
 tb/tb_noise_prng_128e.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/noise_prng_128e.sv
// Masking-noise source for the protected AES-128e stages: a bank of 32-bit
// Galois LFSR lanes with seeding, warm-up, consumer-paced advance and a sticky zero-lane alarm.
module noise_prng_128e #(
  parameter int L_W     = 8,
  parameter int NSTAGES = 1,
  parameter int WARMUP  = 16,
  localparam int NOISE_W = NSTAGES * 7 * L_W,
  localparam int LANES   = (NOISE_W + 31) / 32
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               reseed_i,
  input  logic [31:0]        seed_i,
  input  logic               advance_i,
  output logic [NOISE_W-1:0] noise_o,
  output logic               valid_o,
  output logic               alarm_o
);

  localparam logic [31:0] POLY       = 32'h80200003;
  localparam logic [7:0]  WARMUP_CNT = 8'(WARMUP);

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             count_reg, count_next;
  logic [LANES*32-1:0]    lanes_reg, lanes_next;
  logic [LANES*32-1:0]    lanes_step, lanes_seed;
  logic [LANES-1:0]       lane_zero;
  logic                   valid_reg, valid_next;
  logic                   alarm_reg, alarm_next;
  logic                   fault;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gen_lane
      // Golden-ratio offsets decorrelate lanes that share one seed word.
      localparam logic [31:0] GOLDEN = 32'(gi) * 32'h9E3779B9;
      logic [31:0] lane_cur;
      logic [31:0] lane_mix;
      assign lane_cur = lanes_reg[gi*32 +: 32];
      assign lane_mix = seed_i ^ GOLDEN;
      assign lanes_seed[gi*32 +: 32] = (lane_mix == 32'h0) ? 32'h00000001 : lane_mix;
      assign lanes_step[gi*32 +: 32] = {1'b0, lane_cur[31:1]} ^ (lane_cur[0] ? POLY : 32'h0);
      assign lane_zero[gi] = (lane_cur == 32'h0);
    end
  endgenerate

  // A zero lane is a fixed point of the LFSR, so it can only come from a fault.
  assign fault = (state_reg != ST_IDLE) && (|lane_zero);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    lanes_next = lanes_reg;
    valid_next = valid_reg;
    alarm_next = alarm_reg;
    if (reseed_i) begin
      lanes_next = lanes_seed;
      count_next = WARMUP_CNT;
      state_next = ST_WARMUP;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_WARMUP: begin
          lanes_next = lanes_step;
          count_next = count_reg - 8'd1;
          if (count_reg == 8'd1) begin
            state_next = ST_RUN;
            valid_next = 1'b1;
          end
        end
        ST_RUN: begin
          if (advance_i) lanes_next = lanes_step;
        end
        default: ;
      endcase
    end
    if (fault) begin
      alarm_next = 1'b1;
      if (!reseed_i) state_next = ST_IDLE;
    end
    if (alarm_next) valid_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg <= ST_IDLE;
      count_reg <= 8'd0;
      lanes_reg <= '0;
      valid_reg <= 1'b0;
      alarm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      lanes_reg <= lanes_next;
      valid_reg <= valid_next;
      alarm_reg <= alarm_next;
    end
  end

  assign noise_o = lanes_reg[NOISE_W-1:0];
  assign valid_o = valid_reg;
  assign alarm_o = alarm_reg;

endmodule

// File: tb/tb_noise_prng_128e.sv
// Bench for noise_prng_128e: a WARMUP=1 instance driven from a vector table plus a fault
// sequence, and a WARMUP=16 instance exercising reseed during warm-up.
module tb_noise_prng_128e;

  localparam int NW = 56;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst;
  logic          a_rs, a_adv, b_rs, b_adv;
  logic [31:0]   a_seed, b_seed;
  logic [NW-1:0] a_noise, b_noise;
  logic          a_valid, a_alarm, b_valid, b_alarm;

  noise_prng_128e #(.WARMUP(1)) u_w1 (
    .clk_i(clk), .srst_i(srst), .reseed_i(a_rs), .seed_i(a_seed), .advance_i(a_adv),
    .noise_o(a_noise), .valid_o(a_valid), .alarm_o(a_alarm)
  );

  noise_prng_128e #(.WARMUP(16)) u_w16 (
    .clk_i(clk), .srst_i(srst), .reseed_i(b_rs), .seed_i(b_seed), .advance_i(b_adv),
    .noise_o(b_noise), .valid_o(b_valid), .alarm_o(b_alarm)
  );

  typedef struct {
    logic          rs;
    logic [31:0]   seed;
    logic          adv;
    logic [NW-1:0] noise;
    logic          valid;
    logic          alarm;
  } vec_t;

  typedef struct {
    bit            dut_b;
    bit            chk_noise;
    logic [NW-1:0] noise;
    logic          valid;
    logic          alarm;
    string         tag;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[17];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  // Expected noise word: seed mapped to both lanes, stepped n times, truncated to NW bits.
  function automatic logic [NW-1:0] expect_after(input logic [31:0] seed, input int n);
    logic [31:0] l0, l1;
    logic [63:0] w;
    l0 = seed;
    l1 = seed ^ 32'h9E3779B9;
    if (l0 == 32'h0) l0 = 32'h1;
    if (l1 == 32'h0) l1 = 32'h1;
    for (int k = 0; k < n; k++) begin
      l0 = lfsr_step(l0);
      l1 = lfsr_step(l1);
    end
    w = {l1, l0};
    return w[NW-1:0];
  endfunction

  task automatic cmp(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, act, req);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    logic [NW-1:0] nz;
    logic          v, al;
    nz = e.dut_b ? b_noise : a_noise;
    v  = e.dut_b ? b_valid : a_valid;
    al = e.dut_b ? b_alarm : a_alarm;
    if (e.chk_noise) cmp({e.tag, " noise"}, 64'(nz), 64'(e.noise));
    cmp({e.tag, " valid"}, 64'(v), 64'(e.valid));
    cmp({e.tag, " alarm"}, 64'(al), 64'(e.alarm));
    $display("%s: noise=%h valid=%0b alarm=%0b", e.tag, nz, v, al);
  endtask

  // One clock of stimulus: drive at the falling edge, queue the expectation,
  // then pop and compare shortly after the rising edge.
  task automatic cycle(input bit dut_b, input logic rs, input logic [31:0] seed, input logic adv,
                       input bit chk_noise, input logic [NW-1:0] en, input logic ev,
                       input logic ea, input string tag);
    exp_t e;
    @(negedge clk);
    a_rs = 1'b0; a_adv = 1'b0; b_rs = 1'b0; b_adv = 1'b0;
    if (dut_b) begin b_rs = rs; b_seed = seed; b_adv = adv; end
    else       begin a_rs = rs; a_seed = seed; a_adv = adv; end
    e.dut_b = dut_b; e.chk_noise = chk_noise; e.noise = en; e.valid = ev; e.alarm = ea; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs(sb_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    srst = 1'b1;
    a_rs = 1'b0; a_adv = 1'b0; a_seed = 32'h0;
    b_rs = 1'b0; b_adv = 1'b0; b_seed = 32'h0;

    vecs[0] = '{1'b1, 32'h00000001, 1'b0, 56'h3779B8_00000001, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 56'h1BBCDC_80200003, 1'b1, 1'b0};
    for (int i = 2; i < 12; i++) vecs[i] = '{1'b0, 32'h0, 1'b0, 56'h1BBCDC_80200003, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 32'h0, 1'b1, expect_after(32'h1, 2), 1'b1, 1'b0};
    vecs[13] = '{1'b1, 32'h9E3779B9, 1'b1, 56'h000001_9E3779B9, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 32'h0, 1'b0, expect_after(32'h9E3779B9, 1), 1'b1, 1'b0};
    vecs[15] = '{1'b0, 32'h0, 1'b1, expect_after(32'h9E3779B9, 2), 1'b1, 1'b0};
    vecs[16] = '{1'b0, 32'h0, 1'b0, expect_after(32'h9E3779B9, 2), 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    cmp("reset a noise", 64'(a_noise), 64'h0);
    cmp("reset a valid", 64'(a_valid), 64'h0);
    cmp("reset a alarm", 64'(a_alarm), 64'h0);
    cmp("reset b noise", 64'(b_noise), 64'h0);
    cmp("reset b valid", 64'(b_valid), 64'h0);
    @(negedge clk);
    srst = 1'b0;

    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, '0, 1'b0, 1'b0, "idle advance ignored");

    for (int i = 0; i < 17; i++)
      cycle(1'b0, vecs[i].rs, vecs[i].seed, vecs[i].adv, 1'b1, vecs[i].noise,
            vecs[i].valid, vecs[i].alarm, $sformatf("vec%0d", i));

    // Fault injection: zero the lanes while running.
    @(negedge clk);
    a_rs = 1'b0; a_adv = 1'b0;
    force u_w1.lanes_reg = '0;
    e.dut_b = 1'b0; e.chk_noise = 1'b0; e.noise = '0; e.valid = 1'b0; e.alarm = 1'b1;
    e.tag = "fault detect";
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs(sb_q.pop_front());
    @(negedge clk);
    release u_w1.lanes_reg;

    cycle(1'b0, 1'b1, 32'h00000005, 1'b0, 1'b1, expect_after(32'h5, 0), 1'b0, 1'b1, "alarm reseed");
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, expect_after(32'h5, 1), 1'b0, 1'b1, "alarm warm done");
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, expect_after(32'h5, 2), 1'b0, 1'b1, "alarm advance");

    // Reset asserted alongside a reseed: reset must win.
    @(negedge clk);
    srst = 1'b1; a_rs = 1'b1; a_seed = 32'h00000007;
    @(posedge clk);
    #1;
    cmp("srst clear noise", 64'(a_noise), 64'h0);
    cmp("srst clear valid", 64'(a_valid), 64'h0);
    cmp("srst clear alarm", 64'(a_alarm), 64'h0);
    @(negedge clk);
    srst = 1'b0; a_rs = 1'b0;
    cycle(1'b0, 1'b1, 32'h00000001, 1'b0, 1'b1, expect_after(32'h1, 0), 1'b0, 1'b0, "post-srst seed");
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, expect_after(32'h1, 1), 1'b1, 1'b0, "post-srst valid");

    // WARMUP=16 instance: reseed after 5 warm-up steps restarts the count.
    cycle(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1, expect_after(32'h12345678, 0), 1'b0, 1'b0, "w16 seed1");
    for (int k = 1; k <= 5; k++)
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, expect_after(32'h12345678, k), 1'b0, 1'b0,
            $sformatf("w16 warm1 step%0d", k));
    cycle(1'b1, 1'b1, 32'h9E3779B9, 1'b0, 1'b1, expect_after(32'h9E3779B9, 0), 1'b0, 1'b0, "w16 seed2");
    for (int k = 1; k <= 16; k++)
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, expect_after(32'h9E3779B9, k), (k == 16), 1'b0,
            $sformatf("w16 warm2 step%0d", k));
    for (int k = 0; k < 2; k++)
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, expect_after(32'h9E3779B9, 16), 1'b1, 1'b0,
            $sformatf("w16 hold%0d", k));
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, expect_after(32'h9E3779B9, 17), 1'b1, 1'b0, "w16 advance");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
